rep_sig_gen: RTL and testbench

- Sparse-pipeline primitive that produces the repeat-signal stream consumed by the Repeat block's repsig_data_in port.
- Consumes a 17-bit coordinate stream, emits one repeat token per data coordinate, and forwards stop and done tokens unchanged.
- Sits between a level scanner's coordinate output and a Repeat block, using the same 17-bit valid/ready token protocol as the GLB tile_write/tile_read interfaces.

---
 rtl/rep_sig_gen.sv | 196 +++++++++++++++++++
 tb/tb_rep_sig_gen.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_sig_gen.sv
// rep_sig_gen: turns a level scanner's coordinate tokens into Repeat-block repeat signals.
// Define REP_SIG_PERF_CNT_EN to add the rep_count/tile_count performance counters.
module rep_sig_gen #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W:0]   coord_in,
  input  logic              coord_in_valid,
  output logic              coord_in_ready,
  output logic [DATA_W:0]   repsig_out,
  output logic              repsig_out_valid,
  input  logic              repsig_out_ready,
`ifdef REP_SIG_PERF_CNT_EN
  output logic [31:0]       rep_count,
  output logic [31:0]       tile_count,
`endif
  output logic              err
);

  localparam int TW     = DATA_W + 1;
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [IN_AW:0]  IN_FULL  = (IN_AW + 1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL = (OUT_AW + 1)'(OUT_DEPTH);

  typedef enum logic [1:0] {
    START,
    STREAM,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0]   in_mem  [IN_DEPTH];
  logic [TW-1:0]   out_mem [OUT_DEPTH];
  logic [IN_AW-1:0]  in_wr, in_rd;
  logic [IN_AW:0]    in_cnt;
  logic [OUT_AW-1:0] out_wr, out_rd;
  logic [OUT_AW:0]   out_cnt;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  logic move_en, xfer_ok, last_was_data;
  logic [TW-1:0] in_head, out_head, xlat_tok;
  logic head_is_data, head_is_done, head_is_unknown, out_head_is_done;

  assign in_full   = (in_cnt == IN_FULL);
  assign in_empty  = (in_cnt == '0);
  assign out_full  = (out_cnt == OUT_FULL);
  assign out_empty = (out_cnt == '0);
  assign xfer_ok   = clk_en & tile_en;

  assign in_head         = in_mem[in_rd];
  assign out_head        = out_mem[out_rd];
  assign head_is_data    = !in_head[DATA_W];
  assign head_is_done    = in_head[DATA_W] && (in_head[9:8] == 2'b01);
  assign head_is_unknown = in_head[DATA_W] && in_head[9];
  assign out_head_is_done = out_head[DATA_W] && (out_head[9:8] == 2'b01);

  // Data coordinates collapse to a single R token; every control token passes unchanged.
  assign xlat_tok = head_is_data ? TW'(1) : in_head;

  assign in_push  = coord_in_valid & coord_in_ready & clk_en;
  assign out_pop  = !out_empty & repsig_out_ready & xfer_ok;
  assign in_pop   = !in_empty & move_en & (!out_full | out_pop) & xfer_ok;
  assign out_push = in_pop;

  assign repsig_out_valid = !out_empty & tile_en;
  assign repsig_out       = out_empty ? '0 : out_head;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= START;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      START, STREAM: begin
        if (in_pop) begin
          state_nxt = head_is_done ? DRAIN : STREAM;
        end
      end
      DRAIN: begin
        if (out_pop && out_head_is_done) begin
          state_nxt = START;
        end
      end
      default: state_nxt = START;
    endcase
  end

  // While a tile's done token is still in the output FIFO, nothing new enters or moves.
  always_comb begin
    move_en        = 1'b0;
    coord_in_ready = 1'b0;
    case (state)
      START, STREAM: begin
        move_en        = 1'b1;
        coord_in_ready = !in_full & tile_en & !rst;
      end
      default: begin
        move_en        = 1'b0;
        coord_in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mem[in_wr] <= coord_in;
    end
    if (out_push) begin
      out_mem[out_wr] <= xlat_tok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      in_wr   <= '0;
      in_rd   <= '0;
      in_cnt  <= '0;
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_push) begin
        in_wr <= in_wr + 1'b1;
      end
      if (in_pop) begin
        in_rd <= in_rd + 1'b1;
      end
      if (in_push && !in_pop) begin
        in_cnt <= in_cnt + 1'b1;
      end else if (!in_push && in_pop) begin
        in_cnt <= in_cnt - 1'b1;
      end
      if (out_push) begin
        out_wr <= out_wr + 1'b1;
      end
      if (out_pop) begin
        out_rd <= out_rd + 1'b1;
      end
      if (out_push && !out_pop) begin
        out_cnt <= out_cnt + 1'b1;
      end else if (!out_push && out_pop) begin
        out_cnt <= out_cnt - 1'b1;
      end
    end
  end

  // Unknown tokens leave last_was_data untouched; flush keeps the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err           <= 1'b0;
      last_was_data <= 1'b0;
    end else if (flush) begin
      last_was_data <= 1'b0;
    end else if (in_pop) begin
      if (head_is_data) begin
        last_was_data <= 1'b1;
      end else if (!head_is_unknown) begin
        last_was_data <= 1'b0;
      end
      if (head_is_unknown || (head_is_done && last_was_data)) begin
        err <= 1'b1;
      end
    end
  end

`ifdef REP_SIG_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rep_count  <= '0;
      tile_count <= '0;
    end else if (out_pop) begin
      if (!out_head[DATA_W] && (rep_count != '1)) begin
        rep_count <= rep_count + 1'b1;
      end
      if (out_head_is_done && (tile_count != '1)) begin
        tile_count <= tile_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rep_sig_gen.sv
// Scoreboard bench for rep_sig_gen: directed tiles plus randomized traffic against a token-level model.
// Optional counter checks run when REP_SIG_PERF_CNT_EN is defined.
module tb_rep_sig_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        tile_en = 1'b1;
  logic [16:0] coord_in = '0;
  logic        coord_in_valid = 1'b0;
  logic        coord_in_ready;
  logic [16:0] repsig_out;
  logic        repsig_out_valid;
  logic        repsig_out_ready = 1'b1;
  logic        err;
`ifdef REP_SIG_PERF_CNT_EN
  logic [31:0] rep_count;
  logic [31:0] tile_count;
`endif

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int cons_mode = 0;
  bit rand_en = 1'b0;
  int first_acc_cyc = -1;
  int last_acc_cyc = -1;
  int first_out_cyc = -1;
  int first_err_cyc = -1;
  logic prev_err = 1'b0;
  bit m_lwd = 1'b0;
  bit m_err = 1'b0;
  logic [16:0] exp_q [$];

  logic [16:0] t1 [4] = '{17'h00003, 17'h00007, 17'h10000, 17'h10100};
  logic [16:0] t2 [6] = '{17'h00011, 17'h00022, 17'h10000, 17'h00033, 17'h10001, 17'h10100};
  logic [16:0] t3 [7] = '{17'h00005, 17'h10001, 17'h10100, 17'h10100, 17'h00007, 17'h10000, 17'h10100};

  rep_sig_gen dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .flush            (flush),
    .tile_en          (tile_en),
    .coord_in         (coord_in),
    .coord_in_valid   (coord_in_valid),
    .coord_in_ready   (coord_in_ready),
    .repsig_out       (repsig_out),
    .repsig_out_valid (repsig_out_valid),
    .repsig_out_ready (repsig_out_ready),
`ifdef REP_SIG_PERF_CNT_EN
    .rep_count        (rep_count),
    .tile_count       (tile_count),
`endif
    .err              (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] ref_xlat(input logic [16:0] tok);
    return tok[16] ? tok : 17'h00001;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("[TB] FAIL %s: got timeout, expected completion", name);
  endtask

  // Acceptor: every handshake the DUT will take at the next edge feeds the model.
  initial forever begin
    @(negedge clk);
    if (rst || flush) begin
      exp_q.delete();
      m_lwd = 1'b0;
      if (rst) m_err = 1'b0;
    end else if (coord_in_valid && coord_in_ready && clk_en && tile_en) begin
      exp_q.push_back(ref_xlat(coord_in));
      if (!coord_in[16]) begin
        m_lwd = 1'b1;
      end else if (coord_in[9]) begin
        m_err = 1'b1;
      end else begin
        if (coord_in[8] && m_lwd) m_err = 1'b1;
        m_lwd = 1'b0;
      end
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial forever begin
    @(negedge clk);
    if (repsig_out_valid && first_out_cyc < 0) first_out_cyc = cyc;
    if (err && !prev_err && first_err_cyc < 0) first_err_cyc = cyc;
    prev_err = err;
    if (!rst && !flush && repsig_out_valid && repsig_out_ready && clk_en && tile_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_out: got %h, expected no token", repsig_out);
      end else begin
        checkOutput("out_token", repsig_out, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (cons_mode)
      0:       repsig_out_ready = 1'b1;
      1:       repsig_out_ready = 1'b0;
      default: repsig_out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (rand_en) begin
      clk_en  = ($urandom_range(0, 7) != 0);
      tile_en = ($urandom_range(0, 9) != 0);
    end
  end

  task automatic set_cons(input int m);
    cons_mode = m;
    if (m == 0) repsig_out_ready = 1'b1;
    if (m == 1) repsig_out_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [16:0] tok, output int stalls);
    int waited = 0;
    bit acc = 1'b0;
    stalls = 0;
    coord_in = tok;
    coord_in_valid = 1'b1;
    while (!acc && waited < 500) begin
      @(negedge clk);
      acc = coord_in_valid && coord_in_ready && clk_en && tile_en && !rst && !flush;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      waited++;
    end
    coord_in_valid = 1'b0;
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    coord_in_valid = 1'b0;
    while ((exp_q.size() != 0 || repsig_out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    coord_in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic check_idle(input string name, input logic exp_err);
    @(negedge clk);
    checkOutput({name, "_valid"}, repsig_out_valid, 0);
    checkOutput({name, "_ready"}, coord_in_ready, 1);
    checkOutput({name, "_data"}, repsig_out, 0);
    checkOutput({name, "_err"}, err, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st, st_sum, idx, gap;
    logic [16:0] tok;
    int r;

    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st, st_sum, idx, gap, r;
    logic [16:0] tok;

    do_reset();
    check_idle("reset", 1'b0);

    // Basic stream: latency and sustained throughput.
    first_acc_cyc = -1;
    first_out_cyc = -1;
    st_sum = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(t1[i], st);
      st_sum += st;
    end
    wait_drain("t1_drain");
    checkOutput("t1_latency", first_out_cyc - first_acc_cyc, 2);
    checkOutput("t1_stalls", st_sum, 0);
    checkOutput("t1_err", err, 0);

    // Backpressure: only IN_DEPTH+OUT_DEPTH tokens fit.
    do_reset();
    set_cons(1);
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      coord_in = t2[idx];
      coord_in_valid = 1'b1;
      @(negedge clk);
      if (coord_in_valid && coord_in_ready && clk_en && tile_en && idx < 5) idx++;
      @(posedge clk);
      #1;
    end
    coord_in_valid = 1'b0;
    checkOutput("bp_accepts", idx, 4);
    set_cons(0);
    for (int i = idx; i < 6; i++) applyStimulus(t2[i], st);
    wait_drain("bp_drain");
    checkOutput("bp_err", err, 0);

    // Back-to-back tiles: DRAIN must block the producer.
    do_reset();
    st_sum = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(t3[i], st);
      st_sum += st;
    end
    wait_drain("tile_drain");
    checkOutput("tile_drain_blocks", (st_sum >= 1), 1);
    checkOutput("tile_err", err, 0);

    // Malformed done: sticky through flush, cleared by reset.
    do_reset();
    first_err_cyc = -1;
    applyStimulus(17'h00002, st);
    applyStimulus(17'h10100, st);
    wait_drain("err_drain");
    checkOutput("err_set", err, 1);
    checkOutput("err_timing", first_err_cyc - last_acc_cyc, 2);
    pulse_flush();
    @(negedge clk);
    checkOutput("err_after_flush", err, 1);
    checkOutput("flush_valid", repsig_out_valid, 0);
    @(posedge clk);
    #1;
    do_reset();
    check_idle("err_reset", 1'b0);

    // Reset with tokens in flight.
    set_cons(1);
    applyStimulus(17'h00004, st);
    applyStimulus(17'h10000, st);
    applyStimulus(17'h00006, st);
    @(posedge clk);
    #1;
    do_reset();
    check_idle("midreset", 1'b0);
    set_cons(0);
    applyStimulus(17'h00009, st);
    wait_drain("midreset_drain");

`ifdef REP_SIG_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(17'(i + 1), st);
    applyStimulus(17'h10000, st);
    applyStimulus(17'h10100, st);
    wait_drain("perf_drain");
    checkOutput("rep_count", rep_count, 5);
    checkOutput("tile_count", tile_count, 1);
    pulse_flush();
    @(negedge clk);
    checkOutput("rep_count_flush", rep_count, 0);
    checkOutput("tile_count_flush", tile_count, 0);
    @(posedge clk);
    #1;
`endif

    // Randomized traffic with back-pressure, clock-enable and tile-enable gaps.
    do_reset();
    set_cons(2);
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      tok = {1'b0, 16'($urandom)};
      else if (r < 80) tok = {1'b1, 6'($urandom), 2'b00, 8'($urandom)};
      else if (r < 95) tok = 17'h10100;
      else             tok = {1'b1, 6'($urandom), 1'b1, 1'($urandom), 8'($urandom)};
      applyStimulus(tok, st);
      if ($urandom_range(0, 3) == 0) begin
        gap = $urandom_range(1, 3);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_en = 1'b0;
    clk_en = 1'b1;
    tile_en = 1'b1;
    set_cons(0);
    wait_drain("rand_drain");
    checkOutput("rand_err", err, m_err);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
